ai_spawn_scheduler: RTL and testbench

//  Enemy-AI decision stage that sits directly upstream of the per-gate spawn blocks (AND/OR/NOT).

---
 rtl/spawn_pkg.sv | 31 +++
 rtl/spawn_lfsr8.sv | 19 +
 rtl/ai_spawn_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_ai_spawn_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spawn_pkg.sv
// spawn_pkg: shared types and constants for the enemy-AI spawn scheduler.
package spawn_pkg;

    typedef enum logic [1:0] {
        U_NOT = 2'd0,
        U_AND = 2'd1,
        U_OR  = 2'd2
    } unit_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHOOSE   = 2'd1,
        REQUEST  = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam logic [4:0] COST_NOT  = 5'd2;
    localparam logic [4:0] COST_AND  = 5'd3;
    localparam logic [4:0] COST_OR   = 5'd4;
    localparam logic [9:0] TOP_MAX_Y = 10'd239;

    // Elixir price of a unit type, in the 5-bit internal elixir arithmetic.
    function automatic logic [4:0] unit_cost(input unit_t u);
        case (u)
            U_NOT:   return COST_NOT;
            U_AND:   return COST_AND;
            default: return COST_OR;
        endcase
    endfunction

endpackage

// File: rtl/spawn_lfsr8.sv
// spawn_lfsr8: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded 8'hA5 at reset.
// Used to break lane ties when SPAWN_RANDOM_LANE_EN is defined.
module spawn_lfsr8 (
    input  logic       en,
    input  logic       Clk,
    input  logic       reset_n,
    output logic [7:0] q
);

    // Step the sequence once per enable; the seed reloads on reset.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 8'hA5;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/ai_spawn_scheduler.sv
// ai_spawn_scheduler: enemy-AI decision stage ahead of the AND/OR/NOT spawn blocks.
// Tracks an elixir budget, counts player threats per lane, picks a unit and lane,
// and holds one spawn request until that block acknowledges it.
// Build option: define SPAWN_RANDOM_LANE_EN to break lane ties with spawn_lfsr8 bit 0
// instead of the alternating lane_alt flag.
module ai_spawn_scheduler
    import spawn_pkg::*;
#(
    parameter int ELIXIR_MAX      = 10,
    parameter int ELIXIR_FRAMES   = 45,
    parameter int COOLDOWN_FRAMES = 60,
    parameter int REQ_TIMEOUT     = 8,
    parameter int THREAT_X        = 300
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic [9:0] pX [4],
    input  logic [9:0] pY [4],
    input  logic       and_dep,
    input  logic       or_dep,
    input  logic       not_dep,
    output logic       and_left,
    output logic       and_right,
    output logic       or_left,
    output logic       or_right,
    output logic       not_left,
    output logic       not_right,
    output logic [3:0] elixir,
    output logic [1:0] state_o
);

    localparam int ECW = $clog2(ELIXIR_FRAMES);
    localparam int FCW = $clog2((COOLDOWN_FRAMES > REQ_TIMEOUT) ? COOLDOWN_FRAMES : REQ_TIMEOUT);

    state_t         state;
    state_t         state_nxt;
    logic           vsync_q1;
    logic           vsync_q2;
    logic           ftick;
    logic           and_dep_q;
    logic           or_dep_q;
    logic           not_dep_q;
    logic [ECW-1:0] ecnt;
    logic [FCW-1:0] fcnt;
    unit_t          sel_q;
    logic           lane_q;
    logic [2:0]     top_cnt;
    logic [2:0]     bot_cnt;
    logic [2:0]     total_cnt;
    logic [4:0]     elix5;
    logic           ok_or;
    logic           ok_and;
    logic           ok_not;
    logic           found;
    unit_t          pick;
    logic           tie_bit;
    logic           lane_pick;
    logic           sel_dep;
    logic           sel_dep_q;
    logic           ack;
    logic           elix_inc;
    logic [4:0]     elix_sum;

    // Synchronise vsync and keep last-cycle deploy status for edge detection.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q1  <= 1'b0;
            vsync_q2  <= 1'b0;
            and_dep_q <= 1'b0;
            or_dep_q  <= 1'b0;
            not_dep_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop here samples pre-edge values; blocking would collapse the synchroniser.
            vsync_q1  <= vsync;
            vsync_q2  <= vsync_q1;
            and_dep_q <= and_dep;
            or_dep_q  <= or_dep;
            not_dep_q <= not_dep;
        end
    end

    assign ftick = vsync_q1 & ~vsync_q2;

    // Count on-field player units close enough to threaten, split by lane.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
        top_cnt = 3'd0;
        bot_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if ((pX[i] != 10'd0) && (pX[i] <= 10'(THREAT_X))) begin
                if (pY[i] <= TOP_MAX_Y) top_cnt = top_cnt + 3'd1;
                else                    bot_cnt = bot_cnt + 3'd1;
            end
        end
        total_cnt = top_cnt + bot_cnt;
    end

    // Preferred unit by threat level, falling back to cheaper idle affordable units.
    always_comb begin
        elix5  = {1'b0, elixir};
        ok_or  = (total_cnt >= 3'd2) && !or_dep  && (elix5 >= unit_cost(U_OR));
        ok_and = (total_cnt >= 3'd1) && !and_dep && (elix5 >= unit_cost(U_AND));
        ok_not = !not_dep && (elix5 >= unit_cost(U_NOT));
        found  = ok_or | ok_and | ok_not;
        if (ok_or)       pick = U_OR;
        else if (ok_and) pick = U_AND;
        else             pick = U_NOT;
        lane_pick = (bot_cnt > top_cnt) || ((bot_cnt == top_cnt) && tie_bit);
    end

`ifdef SPAWN_RANDOM_LANE_EN
    logic [7:0] lfsr_q;

    spawn_lfsr8 u_lfsr (
        .en      (ftick),
        .Clk     (Clk),
        .reset_n (reset_n),
        .q       (lfsr_q)
    );

    assign tie_bit = lfsr_q[0];
`else
    logic lane_alt;

    // Alternate the tie-break lane after every successful deploy.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)  lane_alt <= 1'b0;
        else if (ack)  lane_alt <= ~lane_alt;
    end

    assign tie_bit = lane_alt;
`endif

    // Ack is a rising edge on the selected block's deploy status while requesting.
    always_comb begin
        case (sel_q)
            U_AND:   begin sel_dep = and_dep; sel_dep_q = and_dep_q; end
            U_OR:    begin sel_dep = or_dep;  sel_dep_q = or_dep_q;  end
            default: begin sel_dep = not_dep; sel_dep_q = not_dep_q; end
        endcase
        ack = (state == REQUEST) && sel_dep && !sel_dep_q;
    end

    // State register.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; everything advances on frame ticks except the ack.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (ftick) state_nxt = CHOOSE;
            CHOOSE:   if (ftick) state_nxt = found ? REQUEST : IDLE;
            REQUEST: begin
                if (ack)
                    state_nxt = COOLDOWN;
                else if (ftick && (fcnt == FCW'(REQ_TIMEOUT - 1)))
                    state_nxt = IDLE;
            end
            COOLDOWN: if (ftick && (fcnt == FCW'(COOLDOWN_FRAMES - 1))) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request outputs: exactly one asserted, and only while in REQUEST.
    always_comb begin
        {and_left, and_right, or_left, or_right, not_left, not_right} = 6'b0;
        if (state == REQUEST) begin
            case (sel_q)
                U_AND:   if (lane_q) and_left = 1'b1; else and_right = 1'b1;
                U_OR:    if (lane_q) or_left  = 1'b1; else or_right  = 1'b1;
                default: if (lane_q) not_left = 1'b1; else not_right = 1'b1;
            endcase
        end
    end

    assign state_o = state;

    // Latch the chosen unit/lane and run the per-state frame counter.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q  <= U_NOT;
            lane_q <= 1'b0;
            fcnt   <= '0;
        end else begin
            if ((state == CHOOSE) && ftick && found) begin
                sel_q  <= pick;
                lane_q <= lane_pick;
            end
            if (state_nxt != state)
                fcnt <= '0;
            else if (ftick && ((state == REQUEST) || (state == COOLDOWN)))
                fcnt <= fcnt + 1'b1;
        end
    end

    // Elixir: charge on ack and regenerate on frame count in one saturating sum.
    // CHOOSE only commits when elixir >= cost and elixir never drops while
    // requesting, so the subtraction cannot underflow.
    assign elix_inc = ftick && (ecnt == ECW'(ELIXIR_FRAMES - 1));
    assign elix_sum = {1'b0, elixir} - (ack ? unit_cost(sel_q) : 5'd0) + {4'd0, elix_inc};

    // Elixir register and regeneration frame counter.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            ecnt   <= '0;
            elixir <= 4'd5;
        end else begin
            if (ftick) ecnt <= elix_inc ? '0 : ecnt + 1'b1;
            elixir <= (elix_sum > 5'(ELIXIR_MAX)) ? 4'(ELIXIR_MAX) : elix_sum[3:0];
        end
    end

endmodule

// File: tb/tb_ai_spawn_scheduler.sv
// tb_ai_spawn_scheduler: randomized stimulus against a frame/event-level reference model.
module tb_ai_spawn_scheduler;

    localparam int S_IDLE     = 0;
    localparam int S_CHOOSE   = 1;
    localparam int S_REQUEST  = 2;
    localparam int S_COOLDOWN = 3;
    localparam int ELIXIR_MAX = 10;
    localparam int E_FRAMES   = 45;
    localparam int CD_FRAMES  = 60;
    localparam int TIMEOUT    = 8;
    localparam int N_CYCLES   = 24000;

    logic       Clk;
    logic       reset_n;
    logic       vsync;
    logic [9:0] px [4];
    logic [9:0] py [4];
    logic       and_dep, or_dep, not_dep;
    logic       and_left, and_right, or_left, or_right, not_left, not_right;
    logic [3:0] elixir;
    logic [1:0] state_o;
    logic [5:0] reqs;

    assign reqs = {and_left, and_right, or_left, or_right, not_left, not_right};

    ai_spawn_scheduler dut (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .vsync     (vsync),
        .pX        (px),
        .pY        (py),
        .and_dep   (and_dep),
        .or_dep    (or_dep),
        .not_dep   (not_dep),
        .and_left  (and_left),
        .and_right (and_right),
        .or_left   (or_left),
        .or_right  (or_right),
        .not_left  (not_left),
        .not_right (not_right),
        .elixir    (elixir),
        .state_o   (state_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: unit index 0=NOT, 1=AND, 2=OR.
    int costs [3] = '{2, 3, 4};
    bit m_q1, m_q2;
    bit m_dprev [3];
    int m_state, m_elixir, m_eframes, m_wait, m_unit;
    bit m_left, m_alt;
`ifdef SPAWN_RANDOM_LANE_EN
    logic [7:0] m_lfsr;
`endif

    task automatic model_reset();
        m_q1 = 0; m_q2 = 0;
        for (int i = 0; i < 3; i++) m_dprev[i] = 0;
        m_state = S_IDLE; m_elixir = 5; m_eframes = 0; m_wait = 0;
        m_unit = 0; m_left = 0; m_alt = 0;
`ifdef SPAWN_RANDOM_LANE_EN
        m_lfsr = 8'hA5;
`endif
    endtask

    // Predict the effect of the next rising clock edge given the current inputs.
    task automatic model_step();
        bit dnow [3];
        bit tick, ack, tie;
        int gain, charge, nel, top, bot, want, pick;
        dnow[0] = not_dep; dnow[1] = and_dep; dnow[2] = or_dep;
        tick = m_q1 && !m_q2;
        ack  = (m_state == S_REQUEST) && dnow[m_unit] && !m_dprev[m_unit];
        gain = 0;
        if (tick) begin
            m_eframes++;
            if (m_eframes == E_FRAMES) begin gain = 1; m_eframes = 0; end
        end
        charge = ack ? costs[m_unit] : 0;
        nel = m_elixir - charge + gain;
        if (nel > ELIXIR_MAX) nel = ELIXIR_MAX;
`ifdef SPAWN_RANDOM_LANE_EN
        tie = m_lfsr[0];
`else
        tie = m_alt;
`endif
        case (m_state)
            S_IDLE: if (tick) m_state = S_CHOOSE;
            S_CHOOSE: if (tick) begin
                top = 0; bot = 0;
                for (int i = 0; i < 4; i++)
                    if (px[i] != 10'd0 && px[i] <= 10'd300) begin
                        if (py[i] < 10'd240) top++; else bot++;
                    end
                want = (top + bot >= 2) ? 2 : top + bot;
                pick = -1;
                for (int u = want; u >= 0; u--)
                    if (pick < 0 && !dnow[u] && m_elixir >= costs[u]) pick = u;
                if (pick >= 0) begin
                    m_unit  = pick;
                    m_left  = (bot > top) ? 1'b1 : (top > bot) ? 1'b0 : tie;
                    m_state = S_REQUEST;
                    m_wait  = 0;
                end else begin
                    m_state = S_IDLE;
                end
            end
            S_REQUEST: begin
                if (ack) begin
                    m_state = S_COOLDOWN; m_wait = 0; m_alt = !m_alt;
                end else if (tick) begin
                    m_wait++;
                    if (m_wait == TIMEOUT) m_state = S_IDLE;
                end
            end
            default: if (tick) begin
                m_wait++;
                if (m_wait == CD_FRAMES) m_state = S_IDLE;
            end
        endcase
        m_elixir = nel;
        for (int i = 0; i < 3; i++) m_dprev[i] = dnow[i];
`ifdef SPAWN_RANDOM_LANE_EN
        if (tick) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
        m_q2 = m_q1;
        m_q1 = vsync;
    endtask

    // Bit order matches reqs: {and_l, and_r, or_l, or_r, not_l, not_r}.
    function automatic int exp_req();
        int base;
        if (m_state != S_REQUEST) return 0;
        base = (m_unit == 0) ? 0 : (m_unit == 1) ? 4 : 2;
        return 1 << (base + int'(m_left));
    endfunction

    task automatic drive_inputs(inout int vs_left);
        int k;
        if (vs_left == 0) begin
            vsync   = ~vsync;
            vs_left = int'($urandom_range(2, 6));
        end else begin
            vs_left--;
        end
        if (and_dep) and_dep = ($urandom_range(0, 29) != 0); else and_dep = ($urandom_range(0, 39) == 0);
        if (or_dep)  or_dep  = ($urandom_range(0, 29) != 0); else or_dep  = ($urandom_range(0, 39) == 0);
        if (not_dep) not_dep = ($urandom_range(0, 29) != 0); else not_dep = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 119) == 0) begin
            k = int'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       px[k] = 10'd0;
                1:       px[k] = 10'd300;
                2:       px[k] = 10'd301;
                default: px[k] = 10'($urandom_range(1, 400));
            endcase
            case ($urandom_range(0, 3))
                0:       py[k] = 10'd239;
                1:       py[k] = 10'd240;
                default: py[k] = 10'($urandom_range(0, 479));
            endcase
        end
    endtask

    initial begin
        int vs_left;
        int n_resets;
        reset_n = 1'b0;
        vsync   = 1'b0;
        and_dep = 1'b0; or_dep = 1'b0; not_dep = 1'b0;
        for (int i = 0; i < 4; i++) begin px[i] = 10'd0; py[i] = 10'd0; end
        vs_left  = 3;
        n_resets = 0;
        repeat (3) @(negedge Clk);
        check("reset_state",  32'(state_o), 32'(S_IDLE));
        check("reset_elixir", 32'(elixir),  32'd5);
        check("reset_req",    32'(reqs),    32'd0);
        reset_n = 1'b1;
        model_reset();

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            drive_inputs(vs_left);
            model_step();
            @(negedge Clk);
            check("state",  32'(state_o), 32'(m_state));
            check("elixir", 32'(elixir),  32'(m_elixir));
            check("req",    32'(reqs),    32'(exp_req()));
            if (m_state == S_REQUEST && n_resets < 3 && $urandom_range(0, 59) == 0) begin
                n_resets++;
                #2 reset_n = 1'b0;
                #1;
                check("midreq_rst_req",    32'(reqs),    32'd0);
                check("midreq_rst_state",  32'(state_o), 32'(S_IDLE));
                check("midreq_rst_elixir", 32'(elixir),  32'd5);
                @(negedge Clk);
                reset_n = 1'b1;
                model_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
